// File: rtl/newhope_pkg.sv
// Shared NewHope arithmetic constants (q = 12289, Montgomery radix R = 2^18).
package newhope_pkg;

  localparam int unsigned Q        = 12289;
  localparam int unsigned QINV     = 12287;
  localparam int unsigned R_LOG    = 18;
  localparam int unsigned R2_MOD_Q = 3186;
  localparam int unsigned COEFF_W  = 14;
  localparam int unsigned T_W      = 26;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/mont_redc_core.sv
// Two-stage Montgomery reduction: s = (t + ((t*QINV) mod R) * q) / R, with valid/idx sideband.
module mont_redc_core
  import newhope_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [T_W-1:0]   t,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output coeff_t           s,
  output logic [IDX_W-1:0] out_idx
);

  logic             v2;
  logic [T_W-1:0]   t2;
  logic [R_LOG-1:0] u2;
  logic [IDX_W-1:0] idx2;
  logic [R_LOG-1:0] u_next;
  logic [32:0]      sum;

  // Only the low R_LOG bits of t*QINV matter, so a T_W-bit product suffices.
  assign u_next = R_LOG'(t * T_W'(QINV));
  assign sum    = 33'(t2) + 33'(u2) * 33'(Q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      v2        <= 1'b0;
      t2        <= '0;
      u2        <= '0;
      idx2      <= '0;
      out_valid <= 1'b0;
      s         <= '0;
      out_idx   <= '0;
    end else if (advance) begin
      v2        <= in_valid;
      t2        <= t;
      u2        <= u_next;
      idx2      <= in_idx;
      out_valid <= v2;
      s         <= COEFF_W'(sum >> R_LOG);
      out_idx   <= idx2;
    end
  end

endmodule

// File: rtl/montgomery_encode.sv
// Streams coefficients into Montgomery form (a*R mod q) with valid/ready backpressure.
// MONT_ENC_CANONICAL_EN adds a final conditional subtraction so out_data lies in [0, q).
module montgomery_encode
  import newhope_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [IDX_W-1:0] out_idx
);

  logic             advance;
  coeff_t           a;
  logic             v1;
  logic [T_W-1:0]   t1;
  logic [IDX_W-1:0] idx1;
  logic             s_valid;
  coeff_t           s;
  logic [IDX_W-1:0] s_idx;

  // Whole pipeline moves in lockstep; bubbles are carried, not collapsed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign a        = COEFF_W'(in_data);

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1   <= 1'b0;
      t1   <= '0;
      idx1 <= '0;
    end else if (advance) begin
      v1   <= in_valid && in_ready;
      t1   <= T_W'(a) * T_W'(R2_MOD_Q);
      idx1 <= in_idx;
    end
  end

  mont_redc_core #(
    .IDX_W(IDX_W)
  ) u_redc (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .in_valid (v1),
    .t        (t1),
    .in_idx   (idx1),
    .out_valid(s_valid),
    .s        (s),
    .out_idx  (s_idx)
  );

`ifdef MONT_ENC_CANONICAL_EN
  logic             v4;
  coeff_t           d4;
  logic [IDX_W-1:0] idx4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v4   <= 1'b0;
      d4   <= '0;
      idx4 <= '0;
    end else if (advance) begin
      v4   <= s_valid;
      d4   <= (s >= COEFF_W'(Q)) ? s - COEFF_W'(Q) : s;
      idx4 <= s_idx;
    end
  end

  assign out_valid = v4;
  assign out_data  = 16'(d4);
  assign out_idx   = idx4;
`else
  assign out_valid = s_valid;
  assign out_data  = 16'(s);
  assign out_idx   = s_idx;
`endif

endmodule

// File: doc/montgomery_encode.md
# montgomery_encode

Converts standard-domain NewHope coefficients (q = 12289) into Montgomery form, out = a·R mod q with R = 2^18. It is the entry-side counterpart of the Montgomery reduction stage. It sits between the polynomial loader and the NTT butterfly array, so coefficients enter the transform already in Montgomery domain. It is a fully pipelined valid/ready stream with backpressure, a coefficient-index sideband, and an optional canonical final subtraction.

## Interface
- Parameters:
- IDX_W, 10, width of the coefficient-index sideband (n = 1024)
- Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  input coefficient present
- in_ready  output  1  block accepts input this cycle
- in_data  input  16  coefficient; only bits [13:0] are used, bits [15:14] are ignored
- in_idx  input  IDX_W  coefficient index, carried alongside the data unchanged
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- out_data  output  16  Montgomery-form coefficient, zero-extended
- out_idx  output  IDX_W  index that entered with this result

## Operation
- Stage 1: t = a·R2, where a = in_data[13:0] and R2 = 3186 (R² mod q). t is 26 bits.
- Stage 2: u = (t·QINV) mod 2^18, where QINV = 12287 (−q⁻¹ mod 2^18). t is registered alongside u.
- Stage 3: s = (t + u·q) >> 18. The sum is computed at 33 bits with no truncation before the shift. s < q + 256.
- Stage 4 (MONT_ENC_CANONICAL_EN only): out = (s ≥ q) ? s − q : s. The result lies in [0, q).
- Inputs ≥ q are legal and are reduced implicitly. The result is always ≡ a·R (mod q).
- Each stage holds a valid bit, data, and idx. There is no other state and no FSM; behaviour is stream pipeline only.
- Stall rule: advance = !out_valid || out_ready. All stage registers update only when advance = 1.
- in_ready = advance, computed combinationally. A transfer happens when in_valid && in_ready.
- The valid bit of stage 1 loads in_valid && in_ready. Bubbles propagate as invalid stages.
- While stalled, out_data and out_idx hold stable and out_valid stays high.

## Timing
- Latency: 4 cycles from the accepting edge to out_valid with the macro, 3 without.
- Throughput is 1 coefficient per cycle when out_ready is held high.
- Reset (reset = 0 at a clock edge):
  - All valid bits clear.
  - out_valid = 0, out_data = 0, out_idx = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-stream discards all in-flight coefficients, with no partial output.
- Simultaneous in_valid and a stall: the input is not accepted and must be held by upstream, per the standard valid/ready rule.
- out_ready deasserting in the cycle out_valid rises: the result is held until accepted.
- No combinational path from in_valid or in_data to any output. in_ready depends only on out_valid and out_ready.

## Configuration
- MONT_ENC_CANONICAL_EN:
  - Defined: stage 4 is present, out_data is in [0, q), and latency is 4.
  - Undefined: stage 4 is omitted, out_data = s is in [0, q+256), latency is 3, and downstream lazy reduction absorbs the excess.

## Structure
- Constants belong in the shared package newhope_pkg: Q = 12289, QINV = 12287, R_LOG = 18, R2_MOD_Q = 3186, COEFF_W = 14.
- Sub-module mont_redc_core implements stages 2–3: 26-bit t in, registered s out, with its own valid bit and an advance enable. It is reusable by the multiplier path.
- Stage 1 and stage 4 plus the handshake live in the top module. DSP inference is expected for both multiplies.

## Test plan
- Reset, then in_data = 1, idx 5, with out_ready = 1 → after 4 cycles out_data = 4075, out_idx = 5, out_valid pulses for 1 cycle.
- Back-to-back inputs 0, 3, 4, 12288, one per cycle → consecutive outputs 0, 12225, 4011, 8214 with no gaps.
- in_data = 16383 and then 12289 (both ≥ q) → 6877 and 0.
- Stream of 8 inputs with out_ready toggling pseudo-randomly → all 8 results are delivered in order with correct idx, none duplicated or dropped, and out_data is stable while stalled.
- reset asserted with 3 coefficients in flight → out_valid is 0 the next cycle, no stale result appears afterwards, and the next input yields a correct result after 4 cycles.
- Build without MONT_ENC_CANONICAL_EN and input 3 → result s ≡ 12225 (mod q), s < 12545, with latency 3.
